// File: rtl/mem_arbiter.sv
// mem_arbiter: alternating-priority arbiter granting CPU port A / DMA port B single 3-cycle accesses to one RAM
module mem_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [7:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_gnt,
  output logic       a_ack,
  output logic [7:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [7:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_gnt,
  output logic       b_ack,
  output logic [7:0] b_rdata,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_write,
  input  logic [7:0] mem_rdata,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t     state_q, state_d;
  logic       lg_q, lg_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  always_comb begin
    state_d   = state_q;
    lg_d      = lg_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    a_ack     = 1'b0;
    b_ack     = 1'b0;
    case (state_q)
      IDLE: begin
        a_gnt = rst & a_req & (~b_req | lg_q);
        b_gnt = rst & b_req & ~a_gnt;
        if (a_gnt | b_gnt) begin
          state_d = ACCESS;
          lg_d    = b_gnt;
          we_d    = b_gnt ? b_we : a_we;
          addr_d  = b_gnt ? b_addr : a_addr;
          wdata_d = b_gnt ? b_wdata : a_wdata;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        a_ack     = rst & ~lg_q;
        b_ack     = rst & lg_q;
        a_rdata_d = lg_q ? a_rdata_q : mem_rdata;
        b_rdata_d = lg_q ? mem_rdata : b_rdata_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      lg_q      <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      lg_q      <= lg_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end
  assign a_rdata   = a_ack ? mem_rdata : a_rdata_q;
  assign b_rdata   = b_ack ? mem_rdata : b_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_write = we_q;
  assign busy      = state_q != IDLE;
endmodule
